axum_ctx_mover: RTL
===================

// Module: axum_ctx_mover
// PURPOSE
//  Bus initiator that saves/restores a whole register context between the
//  memory-mapped register-file window and system memory: a context save or
//  restore without per-register software loads/stores. Sits on the data bus
//  as a second initiator. Talks req/we/be/wdata -> rvalid/rdata/err to the
//  register-file map responder and to memory.
// PARAMETERS
//  AddressWidth   32            bus address width
//  DataWidth      32            bus data width (one register per beat)
//  RfMapBase      32'h0001_0000 base of register-file map window (1kB aligned)
//  FirstReg       1             first register index moved (x0 skipped)
//  LastReg        31            last register index moved (inclusive)
//  TimeoutCycles  255           max cycles waiting for rvalid before abort
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   reset, synchronous, active-high
//  cmd_valid_i     in   1   command request
//  cmd_ready_o     out  1   high in IDLE only; command accepted when valid&ready
//  cmd_save_i      in   1   1 = save (RF -> mem), 0 = restore (mem -> RF)
//  cmd_ctx_i       in   2   target register context
//  cmd_mem_addr_i  in   32  memory base of context image; bits [1:0] ignored
//  busy_o          out  1   transfer in progress
//  done_o          out  1   1-cycle pulse at end of transfer (ok or error)
//  err_o           out  1   valid with done_o: 1 = bus error or timeout
//  m_req_o         out  1   bus request, 1-cycle pulse per beat
//  m_addr_o        out  32  bus word address
//  m_we_o          out  1   bus write enable
//  m_be_o          out  4   byte enables, always 4'hF
//  m_wdata_o       out  32  write data
//  m_rvalid_i      in   1   response valid (reads and writes)
//  m_rdata_i       in   32  read data
//  m_err_i         in   1   response error, qualified by m_rvalid_i
// BEHAVIOUR
//  Reset: IDLE; cmd_ready_o=1; busy_o, done_o, err_o, m_req_o, m_we_o=0;
//   m_addr_o, m_wdata_o=0; m_be_o=4'hF. Index/timeout counters cleared.
//  Accept: in IDLE, on cmd_valid_i&cmd_ready_o latch save, ctx,
//   {mem_addr[31:2],2'b00}; idx<=FirstReg; go RD_REQ next cycle.
//   cmd_* ignored outside IDLE.
//  Addresses: rf_addr = RfMapBase | {ctx,idx,2'b00} (ctx at [8:7], idx at
//   [6:2]). mem_addr = base + (idx-FirstReg)*4, modulo 2^32 (wraps).
//   Save reads rf_addr and writes mem_addr; restore reads mem_addr, writes rf_addr.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ | DONE).
//   RD_REQ: m_req_o=1, m_we_o=0, one cycle; -> RD_WAIT.
//   RD_WAIT: on rvalid&!err latch m_rdata_i into data reg -> WR_REQ.
//   WR_REQ: m_req_o=1, m_we_o=1, m_wdata_o=data reg, one cycle; -> WR_WAIT.
//   WR_WAIT: on rvalid&!err: idx==LastReg -> DONE, else idx++ -> RD_REQ.
//   DONE: done_o=1 for one cycle, err_o per error flag; -> IDLE.
//  At most one outstanding beat; m_req_o never asserted while waiting.
//  m_addr_o/m_we_o/m_wdata_o only meaningful while m_req_o=1.
//  Error: rvalid&m_err_i in either WAIT -> DONE with err_o=1; no further
//   beats; destination is partially updated (no rollback).
//  Timeout: counter clears on entering WAIT and increments each WAIT cycle
//   without rvalid. Reaching TimeoutCycles -> DONE with err_o=1. A
//   late rvalid arriving in any non-WAIT state is ignored.
//  Simultaneous rvalid and timeout in the same cycle: rvalid wins.
//  busy_o=1 in all states except IDLE. cmd_ready_o=1 only in IDLE. The
//   DONE cycle is not ready, so back-to-back commands are 1 cycle apart
//   after done_o.
//  Responder returns 0 for the context currently active in the core. Issuing
//   a command on the active context is a software error; the block does not check it.
//  Reset mid-transfer: next cycle IDLE, m_req_o=0, no done_o pulse. A
//   response arriving after reset is ignored.
//  Latency with 1-cycle responder: 4 cycles/register; full 31-register
//   transfer: done_o 125 cycles after the accept cycle.
// TESTING
//  Save ctx 2, mem 0x8000_0100, 1-cycle responder -> reads 0x0001_0104..0x0001_017C,
//   writes 0x8000_0100..0x8000_0178 with the data read; done_o at cycle 125, err_o=0.
//  Restore ctx 1 from 0x2000_0000 preloaded with idx*0x11 -> RF map writes
//   0x0001_0084.. carry matching data; then read back via map -> identical.
//  m_err_i on 5th read beat -> done_o&err_o next-but-one cycle; exactly 4
//   writes issued; no further m_req_o.
//  Responder silent on a write beat -> done_o&err_o after 255 WAIT cycles;
//   stray rvalid injected in IDLE afterwards has no effect.
//  mem base 0xFFFF_FFF0 with bits[1:0]=2'b11 -> addresses 0xFFFF_FFF0..0xFFFF_FFFC,
//   then wrap to 0x0000_0000 onward.
//  Assert rst_i during WR_WAIT of beat 10 -> IDLE next cycle, no done_o;
//   a new command then completes normally with 125-cycle latency.

Source files
------------

// File: rtl/axum_ctx_mover.sv
// axum_ctx_mover
//
// Second bus initiator that copies a whole register context between the
// memory-mapped register-file window and system memory, one register per
// bus beat. A save reads the register file and writes memory. A restore
// reads memory and writes the register file. Only one beat is outstanding
// at a time: each register costs one read and one write.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake (ready only while idle)
//   cmd_save_i            1 = save (RF -> mem), 0 = restore (mem -> RF)
//   cmd_ctx_i             register context selected in the RF map window
//   cmd_mem_addr_i        word-aligned memory base of the context image
//   busy_o                transfer in progress
//   done_o, err_o         one-cycle completion pulse with error status
//   m_req_o .. m_wdata_o  bus request side (one-cycle request per beat)
//   m_rvalid_i .. m_err_i bus response side
module axum_ctx_mover #(
    parameter int unsigned             AddressWidth  = 32,
    parameter int unsigned             DataWidth     = 32,
    parameter logic [AddressWidth-1:0] RfMapBase     = 32'h0001_0000,
    parameter int unsigned             FirstReg      = 1,
    parameter int unsigned             LastReg       = 31,
    parameter int unsigned             TimeoutCycles = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_save_i,
    input  logic [1:0]                cmd_ctx_i,
    input  logic [AddressWidth-1:0]   cmd_mem_addr_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      m_req_o,
    output logic [AddressWidth-1:0]   m_addr_o,
    output logic                      m_we_o,
    output logic [DataWidth/8-1:0]    m_be_o,
    output logic [DataWidth-1:0]      m_wdata_o,
    input  logic                      m_rvalid_i,
    input  logic [DataWidth-1:0]      m_rdata_i,
    input  logic                      m_err_i
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdReq  = 3'd1;
    localparam logic [2:0] StRdWait = 3'd2;
    localparam logic [2:0] StWrReq  = 3'd3;
    localparam logic [2:0] StWrWait = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);

    localparam logic [4:0]          FirstIdx = 5'(FirstReg);
    localparam logic [4:0]          LastIdx  = 5'(LastReg);
    localparam logic [TmoWidth-1:0] TmoLimit = TmoWidth'(TimeoutCycles);

    logic [2:0]              state_q, state_d;
    logic                    save_q,  save_d;
    logic [1:0]              ctx_q,   ctx_d;
    logic [AddressWidth-1:0] base_q,  base_d;
    logic [4:0]              idx_q,   idx_d;
    logic [DataWidth-1:0]    data_q,  data_d;
    logic [TmoWidth-1:0]     tmo_q,   tmo_d;
    logic                    err_q,   err_d;

    logic [AddressWidth-1:0] rf_addr;
    logic [AddressWidth-1:0] mem_addr;
    logic [AddressWidth-1:0] src_addr;
    logic [AddressWidth-1:0] dst_addr;
    logic [TmoWidth-1:0]     tmo_inc;

    // The RF window is 1kB aligned, so OR-ing in {ctx, idx, 2'b00} is an
    // add. The memory image is packed from FirstReg upward and wraps at 2^32.
    always_comb begin
        rf_addr  = RfMapBase | AddressWidth'({ctx_q, idx_q, 2'b00});
        mem_addr = base_q + (AddressWidth'(idx_q - FirstIdx) << 2);
        src_addr = save_q ? rf_addr  : mem_addr;
        dst_addr = save_q ? mem_addr : rf_addr;
        tmo_inc  = tmo_q + TmoWidth'(1);
    end

    // Sequencer. A response is checked before the timeout, so an rvalid
    // in the last allowed wait cycle still counts.
    always_comb begin
        state_d = state_q;
        save_d  = save_q;
        ctx_d   = ctx_q;
        base_d  = base_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    save_d  = cmd_save_i;
                    ctx_d   = cmd_ctx_i;
                    base_d  = cmd_mem_addr_i & ~AddressWidth'(3);
                    idx_d   = FirstIdx;
                    err_d   = 1'b0;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                tmo_d   = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (m_rvalid_i) begin
                    if (m_err_i) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        data_d  = m_rdata_i;
                        state_d = StWrReq;
                    end
                end else if (tmo_inc == TmoLimit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StWrReq: begin
                tmo_d   = '0;
                state_d = StWrWait;
            end
            StWrWait: begin
                if (m_rvalid_i) begin
                    if (m_err_i) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StRdReq;
                    end
                end else if (tmo_inc == TmoLimit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            save_q  <= 1'b0;
            ctx_q   <= 2'd0;
            base_q  <= '0;
            idx_q   <= 5'd0;
            data_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            save_q  <= save_d;
            ctx_q   <= ctx_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state. Address and data are held at
    // zero outside request cycles, so the bus stays quiet while idle.
    always_comb begin
        cmd_ready_o = (state_q == StIdle);
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
        err_o       = (state_q == StDone) && err_q;
        m_req_o     = (state_q == StRdReq) || (state_q == StWrReq);
        m_we_o      = (state_q == StWrReq);
        m_be_o      = '1;
        m_addr_o    = '0;
        m_wdata_o   = '0;
        if (state_q == StRdReq) begin
            m_addr_o = src_addr;
        end else if (state_q == StWrReq) begin
            m_addr_o  = dst_addr;
            m_wdata_o = data_q;
        end
    end

endmodule
